// File: rtl/pump_pkg.sv
// Shared types for the fragrance pump controller: pump indexing,
// arbiter state encoding and a one-hot helper.
package pump_pkg;

    localparam int NUM_PUMPS  = 3;
    localparam int PUMP_IDX_W = 2;

    typedef logic [PUMP_IDX_W-1:0] pump_idx_t;

    localparam pump_idx_t NO_PUMP = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } pump_state_e;

    function automatic logic [NUM_PUMPS-1:0] pump_onehot(
        input pump_idx_t idx
    );
        logic [NUM_PUMPS-1:0] oh;
        unique case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/pump_rr_picker.sv
// Round-robin pick among eligible pumps, starting after the last owner.
// Ports: eligible (per-pump), last (previous owner) -> pick, valid.
module pump_rr_picker
    import pump_pkg::*;
(
    input  logic [NUM_PUMPS-1:0] eligible,
    input  pump_idx_t            last,
    output pump_idx_t            pick,
    output logic                 valid
);

    // rot[k] is the eligibility of the k-th pump in search order.
    logic [NUM_PUMPS-1:0] rot;
    pump_idx_t            p0;
    pump_idx_t            p1;
    pump_idx_t            p2;

    always_comb begin
        unique case (last)
            2'd0: begin
                p0  = 2'd1;
                p1  = 2'd2;
                p2  = 2'd0;
                rot = {eligible[0], eligible[2], eligible[1]};
            end
            2'd1: begin
                p0  = 2'd2;
                p1  = 2'd0;
                p2  = 2'd1;
                rot = {eligible[1], eligible[0], eligible[2]};
            end
            // last==2 (and the unused code 3) start at pump index 0
            default: begin
                p0  = 2'd0;
                p1  = 2'd1;
                p2  = 2'd2;
                rot = eligible;
            end
        endcase
    end

    always_comb begin
        valid = |eligible;
        if (rot[0]) begin
            pick = p0;
        end else if (rot[1]) begin
            pick = p1;
        end else if (rot[2]) begin
            pick = p2;
        end else begin
            pick = NO_PUMP;
        end
    end

endmodule

// File: rtl/pump_drive_arbiter.sv
// Shares one pump supply among three pump timers: round-robin grant,
// dead-time gap between grants, and a max on-time cut-off with lockout.
// Ports: clk, rst_n, enable, req[2:0] -> pump_drive[2:0], active_id,
//        busy, timeout_pulse[2:0] (all outputs registered).
module pump_drive_arbiter
    import pump_pkg::*;
#(
    parameter int CLOCK_FREQ    = 1_000_000,
    parameter int GAP_CYCLES    = CLOCK_FREQ / 1000,
    parameter int MAX_ON_CYCLES = 5 * CLOCK_FREQ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_PUMPS-1:0] req,
    output logic [NUM_PUMPS-1:0] pump_drive,
    output pump_idx_t            active_id,
    output logic                 busy,
    output logic [NUM_PUMPS-1:0] timeout_pulse
);

    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] MAX_LAST = 32'(MAX_ON_CYCLES - 1);

    pump_state_e          state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    pump_idx_t            last_q, last_d;
    logic [NUM_PUMPS-1:0] lockout_q, lockout_d;
    logic [NUM_PUMPS-1:0] drive_q, drive_d;
    pump_idx_t            aid_q, aid_d;
    logic                 busy_q, busy_d;
    logic [NUM_PUMPS-1:0] to_q, to_d;

    logic [NUM_PUMPS-1:0] eligible;
    pump_idx_t            pick;
    logic                 pick_valid;
    logic                 owner_req;
    logic                 rel_user;
    logic                 expire;

    assign eligible = req & ~lockout_q & {NUM_PUMPS{enable}};

    pump_rr_picker u_picker (
        .eligible (eligible),
        .last     (last_q),
        .pick     (pick),
        .valid    (pick_valid)
    );

    // The one-hot drive register identifies the owner directly.
    assign owner_req = |(drive_q & req);
    assign rel_user  = (state_q == DRIVE) && (!enable || !owner_req);
    // A dropped request wins over a coincident expiry.
    assign expire    = (state_q == DRIVE) && !rel_user
                       && (cnt_q == MAX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 2'd2;
            lockout_q <= '0;
            drive_q   <= '0;
            aid_q     <= NO_PUMP;
            busy_q    <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            lockout_q <= lockout_d;
            drive_q   <= drive_d;
            aid_q     <= aid_d;
            busy_q    <= busy_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    last_d  = pick;
                end
            end
            DRIVE: begin
                if (rel_user || expire) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Lockout holds only while the request stays high.
        lockout_d = (lockout_q & req) | (expire ? drive_q : '0);
    end

    always_comb begin
        drive_d = '0;
        aid_d   = NO_PUMP;
        to_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    drive_d = pump_onehot(pick);
                    aid_d   = pick;
                end
            end
            DRIVE: begin
                if (expire) begin
                    to_d = drive_q;
                end else if (!rel_user) begin
                    drive_d = drive_q;
                    aid_d   = aid_q;
                end
            end
            default: begin
                drive_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign pump_drive    = drive_q;
    assign active_id     = aid_q;
    assign busy          = busy_q;
    assign timeout_pulse = to_q;

endmodule

// File: tb/tb_pump_drive_arbiter.sv
// Self-checking bench for pump_drive_arbiter (GAP=4, MAX_ON=20).
// Per-cycle model comparison plus directed literal checks.
module tb_pump_drive_arbiter;

    localparam int GAPC = 4;
    localparam int MAXC = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] pump_drive;
    logic [1:0] active_id;
    logic       busy;
    logic [2:0] timeout_pulse;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    pump_drive_arbiter #(
        .CLOCK_FREQ    (1_000_000),
        .GAP_CYCLES    (GAPC),
        .MAX_ON_CYCLES (MAXC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .req           (req),
        .pump_drive    (pump_drive),
        .active_id     (active_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 driving, 2 dead time.
    int         m_st = 0;
    int         m_cnt = 0;
    int         m_last = 2;
    logic [1:0] m_owner = 2'd0;
    logic [1:0] m_idx;
    logic [2:0] m_lock = 3'b000;
    logic [2:0] m_lnext;
    logic [2:0] m_elig;
    logic [2:0] m_drive = 3'b000;
    logic [1:0] m_aid = 2'd3;
    logic       m_busy = 1'b0;
    logic [2:0] m_to = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_last = 2; m_lock = 3'b000;
            m_drive = 3'b000; m_aid = 2'd3; m_busy = 1'b0;
            m_to = 3'b000;
        end else begin
            m_to = 3'b000;
            m_lnext = m_lock & req;
            case (m_st)
                0: begin
                    m_elig = req & ~m_lock & {3{enable}};
                    for (int k = 1; k <= 3; k++) begin
                        m_idx = 2'((m_last + k) % 3);
                        if (m_st == 0 && m_elig[m_idx]) begin
                            m_owner = m_idx;
                            m_last = int'(m_idx);
                            m_cnt = 0;
                            m_st = 1;
                        end
                    end
                end
                1: begin
                    if (!enable || !req[m_owner]) begin
                        m_st = 2; m_cnt = 0;
                    end else if (m_cnt == MAXC - 1) begin
                        m_st = 2; m_cnt = 0;
                        m_to[m_owner] = 1'b1;
                        m_lnext[m_owner] = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
                default: begin
                    if (m_cnt == GAPC - 1) begin
                        m_st = 0; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
            m_lock = m_lnext;
            m_drive = (m_st == 1) ? 3'(3'b001 << m_owner) : 3'b000;
            m_aid = (m_st == 1) ? m_owner : 2'd3;
            m_busy = (m_st != 0);
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("m_drive", 32'(pump_drive), 32'(m_drive));
            chk("m_aid", 32'(active_id), 32'(m_aid));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_tmo", 32'(timeout_pulse), 32'(m_to));
            chk("onehot", 32'($countones(pump_drive) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int zeros);
        int n;
        zeros = 0;
        n = 0;
        while (pump_drive == 3'b000 && n < 40) begin
            zeros++;
            n++;
            tick();
        end
        checks++;
        if (pump_drive == 3'b000) begin
            errors++;
            $display("FAIL grant_wait got none want grant");
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    logic [2:0] rr_exp [4];
    int         zeros;
    int         on_cnt;

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        #12 rst_n = 1'b1;
        #1;
        chk("rst_drive", 32'(pump_drive), 32'd0);
        chk("rst_aid", 32'(active_id), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(timeout_pulse), 32'd0);

        // single request
        tick();
        req = 3'b001;
        tick();
        chk("single_drive", 32'(pump_drive), 32'h1);
        chk("single_aid", 32'(active_id), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        req = 3'b000;
        tick();
        chk("single_rel", 32'(pump_drive), 32'd0);
        chk("single_gap_aid", 32'(active_id), 32'd3);
        repeat (3) tick();
        chk("single_gapbusy", 32'(busy), 32'd1);
        tick();
        chk("single_idle", 32'(busy), 32'd0);

        // round robin
        do_reset();
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_grant(zeros);
            chk("rr_grant", 32'(pump_drive), 32'(rr_exp[g]));
            if (g > 0) chk("rr_gap", 32'(zeros), 32'(GAPC + 1));
            repeat (2) tick();
            req = 3'b111 & ~pump_drive;
            tick();
            chk("rr_rel", 32'(pump_drive), 32'd0);
            req = 3'b111;
        end
        req = 3'b000;
        repeat (8) tick();

        // timeout and lockout
        req = 3'b010;
        wait_grant(zeros);
        chk("to_grant", 32'(pump_drive), 32'h2);
        on_cnt = 0;
        while (pump_drive == 3'b010 && on_cnt < 100) begin
            on_cnt++;
            tick();
        end
        chk("to_oncycles", 32'(on_cnt), 32'(MAXC));
        chk("to_pulse", 32'(timeout_pulse), 32'h2);
        tick();
        chk("to_pulse_end", 32'(timeout_pulse), 32'd0);
        repeat (20) tick();
        chk("to_locked", 32'(pump_drive), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        req = 3'b000;
        tick();
        req = 3'b010;
        tick();
        chk("to_regrant", 32'(pump_drive), 32'h2);
        req = 3'b000;
        repeat (8) tick();

        // request drop on the expiry cycle
        req = 3'b001;
        tick();
        chk("sim_grant", 32'(pump_drive), 32'h1);
        repeat (MAXC - 1) tick();
        req = 3'b000;
        tick();
        chk("sim_rel", 32'(pump_drive), 32'd0);
        chk("sim_nopulse", 32'(timeout_pulse), 32'd0);
        req = 3'b001;
        wait_grant(zeros);
        chk("sim_nolock", 32'(pump_drive), 32'h1);
        chk("sim_gap", 32'(zeros), 32'(GAPC + 1));
        req = 3'b000;
        repeat (8) tick();

        // enable drop mid-drive
        req = 3'b100;
        tick();
        chk("en_grant", 32'(pump_drive), 32'h4);
        chk("en_aid", 32'(active_id), 32'd2);
        tick();
        enable = 1'b0;
        tick();
        chk("en_rel", 32'(pump_drive), 32'd0);
        chk("en_gapbusy", 32'(busy), 32'd1);
        repeat (10) tick();
        chk("en_nogrant", 32'(pump_drive), 32'd0);
        chk("en_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        chk("en_regrant", 32'(pump_drive), 32'h4);

        // asynchronous reset mid-drive
        #1 rst_n = 1'b0;
        #1;
        chk("arst_drive", 32'(pump_drive), 32'd0);
        chk("arst_aid", 32'(active_id), 32'd3);
        #1 rst_n = 1'b1;
        req = 3'b111;
        tick();
        chk("arst_first", 32'(pump_drive), 32'h1);
        tick();

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got hang want finish");
        $fatal(1, "watchdog");
    end

endmodule
